// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_HALT   = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_class_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts non-ack cycles of an outstanding memory request and flags a timeout.
// Latency: o_timeout is combinational in the cycle the count would reach TIMEOUT.
// Backpressure: none; an ack in the timeout cycle suppresses the flag.
// Ports: clk, rst_n (async active-low), i_waiting (request outstanding),
//        i_ack (memory completes this cycle), o_timeout (give up this cycle).
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_waiting,
    input  logic i_ack,
    output logic o_timeout
);

    localparam int TW = $clog2(TIMEOUT + 2);

    logic [TW-1:0] r_cnt;

    // Clearing whenever not waiting (or on ack) guarantees a fresh count on
    // every entry into a waiting state, since each entry follows either a
    // non-waiting state or an ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_waiting && !i_ack) begin
            r_cnt <= r_cnt + TW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign o_timeout = 1'b0;
        end else begin : g_timeout
            // r_cnt holds completed waiting cycles; this cycle is the
            // TIMEOUT-th one when r_cnt == TIMEOUT-1.
            assign o_timeout = i_waiting && !i_ack && (r_cnt == TW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Sequencer stepping each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Latency: ALU 4, LOAD 5, STORE 4, BRANCH/JUMP 3 cycles from FETCH entry with single-cycle acks.
// Backpressure: FETCH/MEM stall on mem_ack; a bounded wait faults with a timeout code.
// Ports: clk, reset (async active-low), run, op_class, branch_taken, mem_ack in;
//        memory request/select, datapath enables, pc_src, wb_sel, status and
//        retired-instruction count out.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [2:0]       op_class,
    input  logic             branch_taken,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             ir_en,
    output logic             opnd_en,
    output logic             alu_en,
    output logic             mdr_en,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    op_class_t        r_class;
    logic [1:0]       r_fault;
    logic [CNT_W-1:0] r_count;

    state_t     w_next_state;
    logic [1:0] w_next_fault;
    logic       w_retire;
    logic       w_latch_class;
    logic       w_waiting;
    logic       w_timeout;
    op_class_t  w_op_in;

    assign w_op_in   = op_class_t'(op_class);
    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);

    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .i_waiting (w_waiting),
        .i_ack     (mem_ack),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_class <= OP_ALU;
            r_fault <= FAULT_NONE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_fault <= w_next_fault;
            if (w_latch_class) begin
                r_class <= w_op_in;
            end
            if (w_retire) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_fault  = r_fault;
        w_retire      = 1'b0;
        w_latch_class = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_sel       = 1'b0;
        pc_en         = 1'b0;
        pc_src        = PC_SRC_SEQ;
        ir_en         = 1'b0;
        opnd_en       = 1'b0;
        alu_en        = 1'b0;
        mdr_en        = 1'b0;
        rf_we         = 1'b0;
        wb_sel        = 1'b0;
        halted        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en        = 1'b1;
                    pc_en        = 1'b1;
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                    w_next_fault = FAULT_TIMEOUT;
                end
            end

            ST_DECODE: begin
                opnd_en       = 1'b1;
                w_latch_class = 1'b1;
                case (w_op_in)
                    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JUMP: w_next_state = ST_EXEC;
                    OP_HALT: w_next_state = ST_HALTED;
                    default: begin
                        w_next_state = ST_FAULT;
                        w_next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end

            ST_EXEC: begin
                alu_en = 1'b1;
                case (r_class)
                    OP_ALU:            w_next_state = ST_WB;
                    OP_LOAD, OP_STORE: w_next_state = ST_MEM;
                    OP_BRANCH: begin
                        pc_en    = branch_taken;
                        pc_src   = PC_SRC_BRANCH;
                        w_retire = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_en    = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        w_retire = 1'b1;
                    end
                    // Only legal classes are latched on the way into EXEC;
                    // anything else means corrupted state, so stop safely.
                    default: begin
                        w_next_state = ST_FAULT;
                        w_next_fault = FAULT_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (r_class == OP_STORE);
                if (mem_ack) begin
                    if (r_class == OP_STORE) begin
                        w_retire = 1'b1;
                    end else begin
                        mdr_en       = 1'b1;
                        w_next_state = ST_WB;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                    w_next_fault = FAULT_TIMEOUT;
                end
            end

            ST_WB: begin
                rf_we    = 1'b1;
                wb_sel   = (r_class == OP_LOAD);
                w_retire = 1'b1;
            end

            ST_HALTED: begin
                halted = 1'b1;
            end

            ST_FAULT: begin
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // run is only sampled at instruction boundaries, so dropping it
        // mid-instruction lets the current one finish.
        if (w_retire) begin
            w_next_state = run ? ST_FETCH : ST_IDLE;
        end
    end

    assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALTED) && (r_state != ST_FAULT);
    assign fault_code  = r_fault;
    assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (CNT_W=4, MEM_TIMEOUT=4 build).
// Inputs change 1ns after the rising edge; outputs are checked 2ns later.
module tb_multicycle_ctrl;

    localparam logic [15:0] REQ  = 16'h8000;
    localparam logic [15:0] WE   = 16'h4000;
    localparam logic [15:0] SEL  = 16'h2000;
    localparam logic [15:0] PCEN = 16'h1000;
    localparam logic [15:0] PCS1 = 16'h0400;
    localparam logic [15:0] PCS2 = 16'h0800;
    localparam logic [15:0] IR   = 16'h0200;
    localparam logic [15:0] OPND = 16'h0100;
    localparam logic [15:0] ALU  = 16'h0080;
    localparam logic [15:0] MDR  = 16'h0040;
    localparam logic [15:0] RFWE = 16'h0020;
    localparam logic [15:0] WBS  = 16'h0010;
    localparam logic [15:0] B    = 16'h0008;
    localparam logic [15:0] HLT  = 16'h0004;
    localparam logic [15:0] FC1  = 16'h0001;
    localparam logic [15:0] FC2  = 16'h0002;
    localparam logic [15:0] NONE = 16'h0000;

    localparam logic [2:0] C_ALU  = 3'd0;
    localparam logic [2:0] C_LD   = 3'd1;
    localparam logic [2:0] C_ST   = 3'd2;
    localparam logic [2:0] C_BR   = 3'd3;
    localparam logic [2:0] C_JMP  = 3'd4;
    localparam logic [2:0] C_HALT = 3'd5;
    localparam logic [2:0] C_ILL  = 3'd6;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [2:0] op_class;
    logic       branch_taken;
    logic       mem_ack;
    logic       mem_req, mem_we, mem_sel, pc_en, ir_en, opnd_en, alu_en;
    logic       mdr_en, rf_we, wb_sel, busy, halted;
    logic [1:0] pc_src, fault_code;
    logic [3:0] instr_count;
    logic [15:0] outv;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .CNT_W       (4),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .op_class     (op_class),
        .branch_taken (branch_taken),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel      (mem_sel),
        .pc_en        (pc_en),
        .pc_src       (pc_src),
        .ir_en        (ir_en),
        .opnd_en      (opnd_en),
        .alu_en       (alu_en),
        .mdr_en       (mdr_en),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .busy         (busy),
        .halted       (halted),
        .fault_code   (fault_code),
        .instr_count  (instr_count)
    );

    assign outv = {mem_req, mem_we, mem_sel, pc_en, pc_src, ir_en, opnd_en,
                   alu_en, mdr_en, rf_we, wb_sel, busy, halted, fault_code};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check the decoded outputs, advance.
    task automatic step(input logic ack, input logic [2:0] op, input logic bt,
                        input logic [15:0] exp, input string tag);
        mem_ack      = ack;
        op_class     = op;
        branch_taken = bt;
        #2;
        check(tag, 32'(outv), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] exp);
        check(tag, 32'(instr_count), 32'(exp));
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        mem_ack = 1'b0;
        #2;
        check("rst_outs", 32'(outv), 32'(NONE));
        check_cnt("rst_cnt", 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic fetch_ack(input string tag);
        step(1'b1, C_ALU, 1'b0, REQ | IR | PCEN | B, tag);
    endtask

    initial begin
        reset        = 1'b0;
        run          = 1'b0;
        op_class     = C_ALU;
        branch_taken = 1'b0;
        mem_ack      = 1'b0;
        do_reset();

        // Idle holds while run is low.
        step(1'b0, C_ALU, 1'b0, NONE, "idle_norun");
        run = 1'b1;
        step(1'b0, C_ALU, 1'b0, NONE, "idle_go");

        // ALU with the ack one cycle after the request.
        step(1'b0, C_ALU, 1'b0, REQ | B, "alu_fwait");
        fetch_ack("alu_fack");
        step(1'b0, C_ALU, 1'b0, OPND | B, "alu_dec");
        step(1'b0, C_ALU, 1'b0, ALU | B, "alu_exec");
        check_cnt("alu_cnt_pre", 4'd0);
        step(1'b0, C_ALU, 1'b0, RFWE | B, "alu_wb");
        check_cnt("alu_cnt", 4'd1);

        // LOAD, ack on the 4th MEM cycle (also the timeout boundary).
        fetch_ack("ld_fack");
        step(1'b0, C_LD, 1'b0, OPND | B, "ld_dec");
        step(1'b0, C_ALU, 1'b0, ALU | B, "ld_exec");
        for (int i = 0; i < 3; i++) step(1'b0, C_ALU, 1'b0, REQ | SEL | B, "ld_mwait");
        step(1'b1, C_ALU, 1'b0, REQ | SEL | MDR | B, "ld_mack");
        step(1'b0, C_ALU, 1'b0, RFWE | WBS | B, "ld_wb");
        check_cnt("ld_cnt", 4'd2);

        // STORE, same delayed ack; retires straight from MEM.
        fetch_ack("st_fack");
        step(1'b0, C_ST, 1'b0, OPND | B, "st_dec");
        step(1'b0, C_ALU, 1'b0, ALU | B, "st_exec");
        for (int i = 0; i < 3; i++) step(1'b0, C_ALU, 1'b0, REQ | WE | SEL | B, "st_mwait");
        step(1'b1, C_ALU, 1'b0, REQ | WE | SEL | B, "st_mack");
        check_cnt("st_cnt", 4'd3);

        // Branch taken, branch not taken, jump.
        fetch_ack("bt_fack");
        step(1'b0, C_BR, 1'b0, OPND | B, "bt_dec");
        step(1'b0, C_ALU, 1'b1, ALU | PCEN | PCS1 | B, "bt_exec");
        fetch_ack("bn_fack");
        step(1'b0, C_BR, 1'b1, OPND | B, "bn_dec");
        step(1'b0, C_ALU, 1'b0, ALU | PCS1 | B, "bn_exec");
        fetch_ack("j_fack");
        step(1'b0, C_JMP, 1'b0, OPND | B, "j_dec");
        step(1'b0, C_ALU, 1'b0, ALU | PCEN | PCS2 | B, "j_exec");
        check_cnt("br_cnt", 4'd6);

        // run dropped during EXEC: instruction finishes, then IDLE.
        fetch_ack("rn_fack");
        step(1'b0, C_ALU, 1'b0, OPND | B, "rn_dec");
        run = 1'b0;
        step(1'b0, C_ALU, 1'b0, ALU | B, "rn_exec");
        step(1'b0, C_ALU, 1'b0, RFWE | B, "rn_wb");
        step(1'b1, C_ALU, 1'b0, NONE, "rn_idle");
        check_cnt("rn_cnt", 4'd7);

        // Nine jumps take the 4-bit count 7 -> 15 -> 0.
        run = 1'b1;
        step(1'b0, C_ALU, 1'b0, NONE, "wr_go");
        for (int i = 0; i < 9; i++) begin
            fetch_ack("wr_fack");
            step(1'b0, C_JMP, 1'b0, OPND | B, "wr_dec");
            step(1'b0, C_ALU, 1'b0, ALU | PCEN | PCS2 | B, "wr_exec");
            if (i == 7) check_cnt("wr_cnt15", 4'd15);
        end
        check_cnt("wr_cnt0", 4'd0);

        // Fetch with no ack: faults after 4 waiting cycles, request drops.
        for (int i = 0; i < 4; i++) step(1'b0, C_ALU, 1'b0, REQ | B, "to_wait");
        step(1'b0, C_ALU, 1'b0, FC2, "to_fault");
        step(1'b1, C_ALU, 1'b0, FC2, "to_hold");
        check_cnt("to_cnt", 4'd0);

        // Reset asserted while a LOAD waits in MEM.
        do_reset();
        step(1'b0, C_ALU, 1'b0, NONE, "rm_go");
        fetch_ack("rm_a_fack");
        step(1'b0, C_ALU, 1'b0, OPND | B, "rm_a_dec");
        step(1'b0, C_ALU, 1'b0, ALU | B, "rm_a_exec");
        step(1'b0, C_ALU, 1'b0, RFWE | B, "rm_a_wb");
        check_cnt("rm_cnt1", 4'd1);
        fetch_ack("rm_l_fack");
        step(1'b0, C_LD, 1'b0, OPND | B, "rm_l_dec");
        step(1'b0, C_ALU, 1'b0, ALU | B, "rm_l_exec");
        step(1'b0, C_ALU, 1'b0, REQ | SEL | B, "rm_l_mwait");
        do_reset();

        // Illegal class.
        step(1'b0, C_ALU, 1'b0, NONE, "il_go");
        fetch_ack("il_fack");
        step(1'b0, C_ILL, 1'b0, OPND | B, "il_dec");
        step(1'b0, C_ALU, 1'b0, FC1, "il_fault");
        step(1'b1, C_ALU, 1'b0, FC1, "il_hold");

        // HALT after one ALU retire: sticky, count unchanged.
        do_reset();
        step(1'b0, C_ALU, 1'b0, NONE, "h_go");
        fetch_ack("h_a_fack");
        step(1'b0, C_ALU, 1'b0, OPND | B, "h_a_dec");
        step(1'b0, C_ALU, 1'b0, ALU | B, "h_a_exec");
        step(1'b0, C_ALU, 1'b0, RFWE | B, "h_a_wb");
        fetch_ack("h_fack");
        step(1'b0, C_HALT, 1'b0, OPND | B, "h_dec");
        step(1'b0, C_ALU, 1'b0, HLT, "h_halted");
        step(1'b1, C_ALU, 1'b0, HLT, "h_hold");
        check_cnt("h_cnt", 4'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequencer for the multicycle test-processor datapath.
- Steps each instruction through FETCH / DECODE / EXEC / MEM / WB over a shared request/ack memory port.
- Drives the write enables of the datapath's enable-registers (PC, IR, MDR, operand, ALU-out) and the register-file write.
- ISA-independent: consumes only a 3-bit op class and a branch-taken flag from the decoder.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 16, max cycles waiting for mem_ack before fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  permit to start/continue instruction execution
- op_class  in  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 reserved
- branch_taken  in  1  branch condition, valid in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write request (STORE data phase)
- mem_sel  out  1  address select: 0 PC (fetch), 1 ALU-out (data)
- pc_en  out  1  PC register write enable
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target
- ir_en  out  1  instruction register enable
- opnd_en  out  1  operand A/B register enable
- alu_en  out  1  ALU-out register enable
- mdr_en  out  1  memory data register enable
- rf_we  out  1  register-file write enable
- wb_sel  out  1  writeback source: 0 ALU-out, 1 MDR
- busy  out  1  state not IDLE/HALTED/FAULT
- halted  out  1  HALT executed (sticky)
- fault_code  out  2  0 none, 1 illegal class, 2 memory timeout (sticky)
- instr_count  out  CNT_W  retired instruction count

Behaviour:
- Reset (reset=0, async): state IDLE, latched class 0, wait counter 0, instr_count 0, fault_code 0. All outputs decode to 0 in IDLE.
- Registered: state, latched class, wait counter, instr_count, fault_code.
- Outputs: combinational from state, latched class, mem_ack and branch_taken.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH:
  - mem_req=1, mem_sel=0.
  - On mem_ack, same cycle: ir_en=1, pc_en=1, pc_src=0; next state DECODE.
- DECODE:
  - opnd_en=1; latch op_class.
  - Class 0-4 -> EXEC; 5 -> HALTED; 6-7 -> FAULT with code 1.
- EXEC: alu_en=1.
  - ALU -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: pc_en=branch_taken, pc_src=1; retire.
  - JUMP: pc_en=1, pc_src=2; retire.
- MEM:
  - mem_req=1, mem_sel=1, mem_we=(class==STORE).
  - On mem_ack: LOAD -> mdr_en=1, then WB; STORE -> retire.
- WB: rf_we=1, wb_sel=(class==LOAD); retire.
- Retire:
  - instr_count+1, wrapping at 2^CNT_W.
  - Next state FETCH if run=1, else IDLE.
- run=0 mid-instruction does not abort; the instruction completes before returning to IDLE.
- Memory handshake:
  - mem_req, mem_we and mem_sel are held stable until the ack cycle.
  - mem_ack outside FETCH/MEM is ignored.
  - The ack cycle is the request's last cycle; at most one transfer per request.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each non-ack cycle.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with no ack: FAULT, code 2, mem_req drops next cycle.
  - An ack on that same cycle wins.
- HALTED: halted=1. FAULT: fault_code held. Both are absorbing until reset.
- Single-cycle-ack latencies: ALU 4, LOAD 5, STORE 4, BRANCH/JUMP 3 cycles, FETCH entry to retire.
- Reset asserted mid-instruction returns to IDLE immediately; the in-flight request is abandoned.

Decomposition:
- Package ctrl_pkg: state_t enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, FAULT), op_class_t encodings, pc_src and fault_code constants.
- Optional sub-module mem_wait_timer (counter plus timeout compare).
- The remainder is one FSM plus an output decode.

Test Plan:
- ALU, run=1, mem_ack one cycle after each req -> per instruction: ir_en/pc_en in ack cycle, rf_we with wb_sel=0 in WB; instr_count 0->1; DECODE-to-retire = 3 cycles.
- LOAD then STORE, ack delayed 3 cycles -> MEM holds mem_req=1/mem_sel=1 for 4 cycles; LOAD: mdr_en on ack, rf_we with wb_sel=1; STORE: mem_we=1, no rf_we; count +2.
- BRANCH taken=1 then taken=0, then JUMP -> pc_en with pc_src=1; then pc_en=0; then pc_en with pc_src=2; no rf_we throughout.
- op_class=6 -> FAULT, fault_code=1, busy=0, no further mem_req. op_class=5 -> halted=1 persistent, count unchanged.
- MEM_TIMEOUT=4, mem_ack never -> fault_code=2 after 4 waiting cycles. Ack on the 4th cycle -> normal completion.
- Deassert run during EXEC -> instruction retires then IDLE. Assert reset in MEM -> outputs 0, count 0. Count from 2^CNT_W-1 retires -> wraps to 0 (CNT_W=4 build).
